// File: rtl/prime_sweep_if.sv
// Output stream of the prime scanner: one registered word plus valid/ready.
interface prime_sweep_if #(
   parameter int W = 5
);
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/prime_sweep.sv
// Range scanner in front of the 5-bit combinational prime detector.
// Steps num through [lo, hi], samples is_prime in the same cycle and
// pushes each prime into a single-entry valid/ready output register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold their last values
// ST_SCAN  | num on the detector, one number per edge unless stalled
// ST_DRAIN | range finished; wait for the last prime to be taken, pulse done
module prime_sweep #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   output logic [W-1:0] num,
   input  logic         is_prime,
   output logic [5:0]   prime_count,
   output logic         busy,
   output logic         done,
   prime_sweep_if.master out_if
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] num_q, num_d;
   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         out_valid_q, out_valid_d;
   logic [5:0]   prime_count_q, prime_count_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic         slot_free;
   logic         at_hi;

   // The output register can take a new word if empty or being emptied now.
   assign slot_free = !out_valid_q || out_if.out_ready;
   // End of range is an equality compare so hi = all-ones never needs a wrap.
   assign at_hi     = (num_q == hi_q);

   // Next-state and output-register logic.
   always_comb begin
      state_d       = state_q;
      num_d         = num_q;
      hi_d          = hi_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      prime_count_d = prime_count_q;
      done_d        = 1'b0;

      // A handshake retires the current word unless a new prime replaces it.
      if (out_valid_q && out_if.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               hi_d          = hi;
               prime_count_d = '0;
               if (lo <= hi) begin
                  num_d   = lo;
                  state_d = ST_SCAN;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end

         ST_SCAN: begin
            // A prime with nowhere to go freezes num, count and state.
            if (!(is_prime && !slot_free)) begin
               if (is_prime) begin
                  out_data_d    = num_q;
                  out_valid_d   = 1'b1;
                  prime_count_d = prime_count_q + 6'd1;
               end
               if (at_hi) begin
                  state_d = ST_DRAIN;
               end else begin
                  num_d = num_q + W'(1);
               end
            end
         end

         ST_DRAIN: begin
            if (slot_free) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // All state and registered outputs; reset drops any pending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         num_q         <= '0;
         hi_q          <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         prime_count_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         num_q         <= num_d;
         hi_q          <= hi_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         prime_count_q <= prime_count_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign num              = num_q;
   assign prime_count      = prime_count_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_data_q;

endmodule

// File: tb/tb_prime_sweep.sv
// Scoreboard bench for prime_sweep: stimulus pushes the primes expected in
// each range, a negedge monitor pops them on every output handshake.
module tb_prime_sweep;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] lo, hi, num;
   logic         is_prime;
   logic [5:0]   prime_count;
   logic         busy, done;
   logic [31:0]  prime_mask;

   prime_sweep_if #(.W(W)) sif ();

   prime_sweep #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .lo          (lo),
      .hi          (hi),
      .num         (num),
      .is_prime    (is_prime),
      .prime_count (prime_count),
      .busy        (busy),
      .done        (done),
      .out_if      (sif)
   );

   always #5 clk = ~clk;

   // Stand-in for the combinational detector: a bitmask of primes below 32.
   assign prime_mask = 32'hA08A28AC;
   assign is_prime   = prime_mask[num];

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];
   int done_cnt = 0;
   bit valid_seen = 1'b0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Reference primality by trial division.
   function automatic bit ref_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int push_range(input int l, input int h);
      int c = 0;
      for (int n = l; n <= h; n++) begin
         if (ref_prime(n)) begin
            exp_q.push_back(n);
            c++;
         end
      end
      return c;
   endfunction

   // Monitor: a word is consumed at the edge following a negedge with valid & ready.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         if (sif.out_valid) valid_seen = 1'b1;
         if (sif.out_valid && sif.out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stream_extra: got %0d, expected no word", sif.out_data);
            end else begin
               chk("stream", int'(sif.out_data), exp_q.pop_front());
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_num"},   int'(num), 0);
      chk({tag, "_valid"}, int'(sif.out_valid), 0);
      chk({tag, "_data"},  int'(sif.out_data), 0);
      chk({tag, "_count"}, int'(prime_count), 0);
      chk({tag, "_busy"},  int'(busy), 0);
      chk({tag, "_done"},  int'(done), 0);
   endtask

   // Issue start for [l, h]; returns just after the accepting edge E0.
   task automatic do_start(input int l, input int h, output int exp_cnt);
      @(posedge clk);
      #1;
      lo      = W'(l);
      hi      = W'(h);
      start   = 1'b1;
      exp_cnt = push_range(l, h);
      @(posedge clk);
      #1;
      start = 1'b0;
      lo    = W'($urandom_range(0, 31));
      hi    = W'($urandom_range(0, 31));
      chk("start_busy", int'(busy), 1);
      if (l <= h) chk("start_num", int'(num), l);
   endtask

   task automatic wait_done(input bit rnd, input int limit, output int edges);
      edges = 0;
      while (!done && edges < limit) begin
         @(posedge clk);
         #1;
         edges++;
         if (rnd) sif.out_ready = 1'($urandom_range(0, 1));
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int cnt, edges, d0;
      rst_n = 1'b0;
      start = 1'b0;
      lo = '0;
      hi = '0;
      sif.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Asynchronous reset in the middle of a sweep, random inputs applied
      do_start(int'($urandom_range(0, 8)), 31, cnt);
      repeat (6) begin
         @(posedge clk);
         #1;
         sif.out_ready = 1'($urandom_range(0, 1));
      end
      #2;
      start = 1'($urandom_range(0, 1));
      lo    = W'($urandom_range(0, 31));
      hi    = W'($urandom_range(0, 31));
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_zero("rst_async");
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         check_zero("rst_idle");
      end

      // Full range with the consumer always ready
      sif.out_ready = 1'b1;
      d0 = done_cnt;
      do_start(0, 31, cnt);
      wait_done(1'b0, 100, edges);
      chk("full_done_edge", edges, 33);
      chk("full_count", int'(prime_count), cnt);
      chk("full_num_end", int'(num), 31);
      chk("full_busy", int'(busy), 0);
      chk("full_valid", int'(sif.out_valid), 0);
      chk("full_sb_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
      chk("full_done_pulse", int'(done), 0);
      chk("full_done_once", done_cnt - d0, 1);

      // Backpressure for three cycles once the first prime appears
      do_start(2, 7, cnt);
      @(posedge clk);
      #1;
      chk("bp_first_valid", int'(sif.out_valid), 1);
      chk("bp_first_data", int'(sif.out_data), 2);
      sif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_data", int'(sif.out_data), 2);
         chk("bp_hold_num", int'(num), 3);
         @(posedge clk);
         #1;
      end
      sif.out_ready = 1'b1;
      wait_done(1'b0, 100, edges);
      chk("bp_count", int'(prime_count), 4);
      chk("bp_sb_empty", exp_q.size(), 0);

      // Boundaries
      do_start(31, 31, cnt);
      wait_done(1'b0, 20, edges);
      chk("b31_count", int'(prime_count), 1);
      chk("b31_sb_empty", exp_q.size(), 0);
      do_start(30, 30, cnt);
      wait_done(1'b0, 20, edges);
      chk("b30_count", int'(prime_count), 0);
      valid_seen = 1'b0;
      do_start(20, 10, cnt);
      wait_done(1'b0, 20, edges);
      chk("inv_done_edge", edges, 1);
      chk("inv_valid_seen", int'(valid_seen), 0);
      chk("inv_count", int'(prime_count), 0);

      // Drain: 31 stalls behind an unconsumed 29
      do_start(29, 31, cnt);
      @(posedge clk);
      #1;
      chk("dr_first_valid", int'(sif.out_valid), 1);
      chk("dr_first_data", int'(sif.out_data), 29);
      sif.out_ready = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("dr_stall_num", int'(num), 31);
         chk("dr_stall_data", int'(sif.out_data), 29);
         chk("dr_stall_busy", int'(busy), 1);
         chk("dr_stall_done", int'(done), 0);
      end
      sif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      sif.out_ready = 1'b0;
      chk("dr_last_data", int'(sif.out_data), 31);
      chk("dr_last_valid", int'(sif.out_valid), 1);
      chk("dr_last_done", int'(done), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("dr_wait_done", int'(done), 0);
         chk("dr_wait_busy", int'(busy), 1);
      end
      sif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("dr_done", int'(done), 1);
      chk("dr_busy", int'(busy), 0);
      chk("dr_valid", int'(sif.out_valid), 0);
      chk("dr_count", int'(prime_count), 2);
      chk("dr_sb_empty", exp_q.size(), 0);

      // Start pulsed mid-sweep with a different range
      do_start(0, 31, cnt);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      lo    = W'(3);
      hi    = W'(4);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0, 100, edges);
      chk("hz_start_edges", edges, 27);
      chk("hz_start_count", int'(prime_count), 11);
      chk("hz_start_sb_empty", exp_q.size(), 0);

      // Reset while num = 9 with a prime pending
      sif.out_ready = 1'b0;
      do_start(7, 15, cnt);
      for (int k = 0; k < 10; k++) begin
         if (num == W'(9)) break;
         @(posedge clk);
         #1;
      end
      chk("hz_num9", int'(num), 9);
      chk("hz_pending", int'(sif.out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_zero("hz_rst");
      @(negedge clk) rst_n = 1'b1;
      sif.out_ready = 1'b1;
      do_start(0, 5, cnt);
      wait_done(1'b0, 50, edges);
      chk("hz_after_count", int'(prime_count), 3);
      chk("hz_after_sb_empty", exp_q.size(), 0);

      // Random ranges with random consumer backpressure
      for (int t = 0; t < 24; t++) begin
         int l, h;
         l = int'($urandom_range(0, 31));
         h = int'($urandom_range(0, 31));
         do_start(l, h, cnt);
         wait_done(1'b1, 400, edges);
         chk("rnd_count", int'(prime_count), cnt);
         chk("rnd_sb_empty", exp_q.size(), 0);
         sif.out_ready = 1'b1;
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/prime_sweep.md
# prime_sweep

Sequential range scanner that sits directly upstream of the 5-bit `primes` detector. It drives the detector's input number, steps it through a programmed range `[lo, hi]`, and samples the detector's combinational `is_prime` result. Each prime found is emitted on a valid/ready output stream, and the block keeps a running count. It turns the stand-alone combinational checker into a self-sequencing enumeration stage for downstream consumers.

## Interface
- `W`, default 5: number width; fixed to match the detector's five inputs `{a,b,c,d,e}`, MSB = `a`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a sweep; sampled only in IDLE.
- `lo` input W: first number to test; captured when `start` is accepted.
- `hi` input W: last number to test, inclusive; captured when `start` is accepted.
- `num` output W: number currently presented to the detector; wired to `{a,b,c,d,e}`.
- `is_prime` input 1: detector output for `num`, valid in the same cycle.
- `out_valid` output 1: `out_data` holds an unconsumed prime.
- `out_ready` input 1: consumer accepts `out_data` at an edge where `out_valid & out_ready`.
- `out_data` output W: prime value.
- `prime_count` output 6: number of primes emitted in the current or last sweep.
- `busy` output 1: high while in SCAN or DRAIN.
- `done` output 1: one-cycle registered pulse at the end of a sweep.

## Operation
- The FSM has three states: IDLE, SCAN, DRAIN. `busy` = (state != IDLE).
- **IDLE, `start` = 1:** the block latches `lo` and `hi` and clears `prime_count`.
  - If `lo <= hi`: `num` <= `lo`, next state is SCAN.
  - If `lo > hi`: next state is DRAIN directly, with no numbers tested.
- **IDLE, `start` = 0:** `num` holds its last value and all outputs hold.
- **SCAN, each edge:** the output slot is *free* if `!out_valid | out_ready`.
  - `is_prime` = 1 and slot free: `out_data` <= `num`, `out_valid` <= 1, `prime_count` += 1, then advance.
  - `is_prime` = 1 and slot not free: stall. `num`, `prime_count` and state hold.
  - `is_prime` = 0: advance. If the slot is free and the old data is consumed, `out_valid` <= 0.
  - Advance: if `num == hi`, next state is DRAIN and `num` holds; otherwise `num` <= `num + 1`.
  - `num` never wraps. The `hi = 31` case is handled by the equality compare, not by overflow.
- **DRAIN, each edge:** if `!out_valid | out_ready`, then `out_valid` <= 0, `done` <= 1, next state is IDLE. Otherwise wait.
- **Output register:** whenever no new prime is loaded, `out_valid` clears on `out_valid & out_ready`.
  - `out_data` holds its value after a handshake and while stalled.
- **`start` while busy:** ignored. The range is not re-latched.
- **`prime_count`:** holds after `done` until the next accepted `start`. Maximum value is 11 (full range 0..31).

## Timing
- **Reset (async assert, any state, including mid-sweep):**
  - State IDLE; `num`, `out_data` = 0; `out_valid`, `busy`, `done` = 0; `prime_count` = 0.
  - Any pending output is dropped.
- **Reset release:** synchronous to `clk`. The first edge with `rst_n` = 1 may accept `start`.
- **Start latency:**
  - The edge E0 that samples `start` sets `busy` = 1 and `num` = `lo`.
  - Edge Ek (k >= 1) evaluates `num = lo + k - 1`, absent stalls.
- **Output latency:** a prime at `num` appears on `out_data`/`out_valid` one cycle after it is presented.
- **Sweep length with `out_ready` held at 1:** N = `hi - lo + 1`.
  - Edges E1..EN evaluate the range, and EN enters DRAIN.
  - At E(N+1): `done` = 1, `busy` = 0, `out_valid` = 0.
  - So `done` is high during the cycle after E(N+1), and `busy` is low from E(N+1).
- **`lo > hi`:** E0 enters DRAIN; `done` pulses after E1; `out_valid` is never asserted.
- **Stalls:** each cycle of backpressure while a prime is pending adds exactly one cycle.
- **Ordering:** no prime is lost or duplicated. Output is in strictly ascending order.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle with random inputs. All outputs read 0 immediately, and stay 0 with `start` = 0 after release.
- **Full sweep:** `lo` = 0, `hi` = 31, `out_ready` = 1. Required results:
  - Stream is 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31.
  - `prime_count` = 11.
  - `done` pulses exactly once, 33 edges after the start edge.
  - `num` ends at 31 with no wrap to 0.
- **Backpressure:** `lo` = 2, `hi` = 7, `out_ready` = 0 for 3 cycles once `out_valid` first rises.
  - `out_data` holds 2 and `num` holds 3 during the stall.
  - Stream is 2, 3, 5, 7 with no loss or duplication; `prime_count` = 4.
  - Also randomise `out_ready` against a golden prime model over all ranges.
- **Boundaries:**
  - `lo` = `hi` = 31: single output 31, `prime_count` = 1.
  - `lo` = `hi` = 30: no output, `prime_count` = 0.
  - `lo` = 20, `hi` = 10: `done` one edge after E0, `out_valid` never high.
- **Drain:** `lo` = 29, `hi` = 31, `out_ready` = 0 after 29 is loaded.
  - The block stalls on 31 and stays in SCAN until 29 is accepted, then emits 31 and waits in DRAIN.
  - `done` rises only on the edge that accepts 31.
- **Control hazards:**
  - `start` pulsed mid-sweep with a new range has no effect.
  - `rst_n` low while `num` = 9 with a prime pending: all outputs are 0 and `busy` = 0.
  - A following `start` with `lo` = 0, `hi` = 5 yields 2, 3, 5 and `prime_count` = 3.
